// File: rtl/digit_serial_triple_multiplier.sv
// Digit-serial unsigned multiplier computing number1*number2*number3 at full precision.
// Phase MUL1 builds number1*number2 one digit of number2 per clock; MUL2 multiplies that by number3 one digit per clock.
module digit_serial_triple_multiplier #(
    parameter int W1    = 6,
    parameter int W2    = 6,
    parameter int W3    = 6,
    parameter int DIGIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W1-1:0]       number1,
    input  logic [W2-1:0]       number2,
    input  logic [W3-1:0]       number3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W1+W2+W3-1:0] result,
    output logic                busy
);
    localparam int DG = (DIGIT > 0) ? DIGIT : 1;
    localparam int N2 = W2 / DG;
    localparam int N3 = W3 / DG;
    localparam int WA = W1 + W2;
    localparam int WR = W1 + W2 + W3;
    localparam int WX = WR + 1;
    localparam int NM = (N2 > N3) ? N2 : N3;
    localparam int KW = (NM > 1) ? $clog2(NM) : 1;

    generate
        if (DIGIT <= 0 || (W2 % DG) != 0 || (W3 % DG) != 0) begin : g_param_check
            $fatal(1, "W2 and W3 must be non-zero multiples of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    state_t          state;
    logic [W1-1:0]   n1;
    logic [W2-1:0]   n2;
    logic [W3-1:0]   n3;
    logic [WA-1:0]   acc1;
    logic [WR-1:0]   acc2;
    logic [KW-1:0]   k;
    logic [31:0]     sh;
    logic [DG-1:0]   d2;
    logic [DG-1:0]   d3;
    logic [WA-1:0]   sum1;
    logic [WR-1:0]   sum2;

    // Products are formed WR+1 wide; the truncation back to the accumulator width drops only zero bits.
    always_comb begin
        sh   = DG * 32'(k);
        d2   = DG'(n2 >> sh);
        d3   = DG'(n3 >> sh);
        sum1 = acc1 + WA'((WX'(n1) * WX'(d2)) << sh);
        sum2 = WR'(((WX'(acc1) * WX'(d3)) << sh) + WX'(acc2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n1        <= '0;
            n2        <= '0;
            n3        <= '0;
            acc1      <= '0;
            acc2      <= '0;
            k         <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        n1       <= number1;
                        n2       <= number2;
                        n3       <= number3;
                        acc1     <= '0;
                        acc2     <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL1;
                    end
                end
                MUL1: begin
                    acc1 <= sum1;
                    if (k == KW'(N2 - 1)) begin
                        k     <= '0;
                        state <= MUL2;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                MUL2: begin
                    acc2 <= sum2;
                    if (k == KW'(N3 - 1)) begin
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; afterwards wait for the downstream handshake.
                    if (!out_valid) begin
                        result    <= acc2;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_triple_multiplier.sv
// Directed testbench for digit_serial_triple_multiplier: default 6x6x6/DIGIT=3 instance
// plus two alternative parameterisations exercised with max and random operands.
module tb_digit_serial_triple_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [5:0]  number1, number2, number3;
    logic [17:0] result;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [8:0]  a_number1;
    logic [2:0]  a_number2, a_number3;
    logic [14:0] a_result;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [3:0]  b_number1, b_number3;
    logic [7:0]  b_number2;
    logic [15:0] b_result;

    digit_serial_triple_multiplier dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .number1(number1), .number2(number2), .number3(number3),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    digit_serial_triple_multiplier #(.W1(9), .W2(3), .W3(3), .DIGIT(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .number1(a_number1), .number2(a_number2), .number3(a_number3),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result), .busy(a_busy)
    );

    digit_serial_triple_multiplier #(.W1(4), .W2(8), .W3(4), .DIGIT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .number1(b_number1), .number2(b_number2), .number3(b_number3),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result), .busy(b_busy)
    );

    // Offers one operand set, returns the result and cycles from accepting edge to first out_valid.
    task automatic run_main(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                            output logic [17:0] r, output int lat, output bit rdy_seen);
        number1 = a; number2 = b; number3 = c; in_valid = 1'b1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 20 && !in_ready; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        if (in_ready) rdy_seen = 1'b1;
        r = result;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (result !== 18'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [17:0] r; int lat; bit rdy;
        run_main(6'd63, 6'd63, 6'd63, r, lat, rdy);
        checks++; if (r !== 18'd250047) begin errors++; $display("FAIL basic_result got %0d want 250047", r); end
        checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        checks++; if (rdy) begin errors++; $display("FAIL basic_in_ready_low got high want low while busy"); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %b want 1", busy); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_after_hs got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_patterns;
        logic [5:0]  va [2] = '{6'd5, 6'd0};
        logic [5:0]  vb [2] = '{6'd3, 6'd45};
        logic [5:0]  vc [2] = '{6'd7, 6'd63};
        logic [17:0] ve [2] = '{18'd105, 18'd0};
        logic [17:0] r; int lat; bit rdy;
        for (int i = 0; i < 2; i++) begin
            run_main(va[i], vb[i], vc[i], r, lat, rdy);
            checks++; if (r !== ve[i]) begin errors++; $display("FAIL pattern%0d_result got %0d want %0d", i, r, ve[i]); end
            checks++; if (lat != 5) begin errors++; $display("FAIL pattern%0d_latency got %0d want 5", i, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall;
        logic [17:0] r; int lat; bit rdy; bit bad;
        out_ready = 1'b0;
        run_main(6'd5, 6'd3, 6'd7, r, lat, rdy);
        checks++; if (r !== 18'd105 || lat != 5) begin errors++; $display("FAIL stall_result got %0d lat %0d want 105 lat 5", r, lat); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            number1 = 6'd11; number2 = 6'd13; number3 = 6'd17; in_valid = 1'b1;
            @(posedge clk); #1;
            if (result !== 18'd105 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL stall_hold got res=%0d ov=%b ir=%b want 105 1 0", result, out_valid, in_ready); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 18'd105) begin
            errors++; $display("FAIL stall_once got ov=%b busy=%b res=%0d want 0 0 105", out_valid, busy, result);
        end
    endtask

    task automatic test_reset_mid;
        logic [17:0] r; int lat; bit rdy;
        number1 = 6'd9; number2 = 6'd9; number3 = 6'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 18'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_state got ov=%b busy=%b res=%0d ir=%b want 0 0 0 1", out_valid, busy, result, in_ready);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_main(6'd2, 6'd2, 6'd2, r, lat, rdy);
        checks++; if (r !== 18'd8 || lat != 5) begin errors++; $display("FAIL midrst_next got %0d lat %0d want 8 lat 5", r, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [17:0] rr [2] = '{18'd0, 18'd0};
        int t [2] = '{0, 0};
        int nacc = 0;
        int nres = 0;
        bit hin, hout;
        number1 = 6'd63; number2 = 6'd63; number3 = 6'd63; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 40 && nres < 2; i++) begin
            hin  = in_valid && in_ready;
            hout = out_valid && out_ready;
            if (hout) begin rr[nres] = result; t[nres] = cyc; nres++; end
            @(posedge clk); #1;
            if (hin) begin
                nacc++;
                if (nacc == 1) begin number1 = 6'd5; number2 = 6'd3; number3 = 6'd7; end
                else in_valid = 1'b0;
            end
        end
        checks++; if (nres != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", nres); end
        checks++; if (rr[0] !== 18'd250047) begin errors++; $display("FAIL b2b_first got %0d want 250047", rr[0]); end
        checks++; if (rr[1] !== 18'd105) begin errors++; $display("FAIL b2b_second got %0d want 105", rr[1]); end
        checks++; if (t[1] - t[0] != 7) begin errors++; $display("FAIL b2b_spacing got %0d want 7", t[1] - t[0]); end
    endtask

    task automatic test_sweep_a;
        int x, y, z, lat; logic [14:0] e;
        for (int n = 0; n < 4; n++) begin
            x = (n == 0) ? 511 : int'($urandom_range(0, 511));
            y = (n == 0) ? 7 : int'($urandom_range(0, 7));
            z = (n == 0) ? 7 : int'($urandom_range(0, 7));
            e = 15'(x * y * z);
            a_number1 = 9'(x); a_number2 = 3'(y); a_number3 = 3'(z); a_in_valid = 1'b1;
            for (int i = 0; i < 20 && !a_in_ready; i++) begin @(posedge clk); #1; end
            @(posedge clk); #1;
            a_in_valid = 1'b0;
            lat = -1;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (a_out_valid) begin lat = i; break; end
            end
            checks++; if (a_result !== e || lat != 3) begin
                errors++; $display("FAIL sweep_a%0d got %0d lat %0d want %0d lat 3", n, a_result, lat, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep_b;
        int x, y, z, lat; logic [15:0] e;
        for (int n = 0; n < 4; n++) begin
            x = (n == 0) ? 15 : int'($urandom_range(0, 15));
            y = (n == 0) ? 255 : int'($urandom_range(0, 255));
            z = (n == 0) ? 15 : int'($urandom_range(0, 15));
            e = 16'(x * y * z);
            b_number1 = 4'(x); b_number2 = 8'(y); b_number3 = 4'(z); b_in_valid = 1'b1;
            for (int i = 0; i < 20 && !b_in_ready; i++) begin @(posedge clk); #1; end
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            lat = -1;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (b_out_valid) begin lat = i; break; end
            end
            checks++; if (b_result !== e || lat != 7) begin
                errors++; $display("FAIL sweep_b%0d got %0d lat %0d want %0d lat 7", n, b_result, lat, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1;
        number1 = '0; number2 = '0; number3 = '0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_number1 = '0; a_number2 = '0; a_number3 = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_number1 = '0; b_number2 = '0; b_number3 = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_sweep_a();
        test_sweep_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
